clk_div_ratio_ctrl: RTL and testbench
=====================================

Name: clk_div_ratio_ctrl

Overview:
- Sequences run-time reconfiguration of the programmable clock divider (6-bit division_ratio, clk_divider_enable).
- Arbitrates ratio-change requests from two requesters, e.g. the UART TX and RX prescale logic.
- Applies each change as gate-off → load → settle → done, so the divided clock never sees a ratio change while enabled.
- Lives in the reference_clk domain, directly driving the divider's configuration inputs.

Parameters:
- GATE_CYCLES, 2: cycles clk_divider_enable is held low before a new ratio is loaded (1..15).
- SETTLE_CYCLES, 4: cycles after enable before completion is reported (1..15).
- RESET_RATIO, 6'd2: division_ratio value after reset.

Ports:
- reference_clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 ratio-change request.
- req0_ratio  in  6  requested ratio from requester 0.
- req0_ready  out  1  one-cycle accept strobe for requester 0.
- req1_valid  in  1  requester 1 ratio-change request.
- req1_ratio  in  6  requested ratio from requester 1.
- req1_ready  out  1  one-cycle accept strobe for requester 1.
- division_ratio  out  6  registered ratio to the divider.
- clk_divider_enable  out  1  registered enable to the divider; 0 = divider bypass.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester served by the current done pulse; valid only with done.
- done_bypass  out  1  with done, high if the completed request left the divider in bypass.

Behaviour:
- Reset (sampled on clock edge while reset=1):
  - state=IDLE; division_ratio=RESET_RATIO; clk_divider_enable=0.
  - busy=0; done=0; done_id=0; done_bypass=0; req*_ready=0.
  - Round-robin pointer favours req0; internal counter=0.
- Reset mid-operation: the next edge forces reset values and the in-flight request is discarded with no done. Requesters re-present.
- Handshake:
  - A requester holds valid and ratio stable until it sees ready=1.
  - Ready is asserted combinationally only in IDLE, to the granted requester only.
  - The transfer occurs in that cycle and the ratio is captured in that cycle.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last; pointer updates on every accept.
- States:
  - IDLE: on accept, if captured ratio == division_ratio and clk_divider_enable=1 → DONE (fast path). Otherwise → GATE_OFF with counter=0.
  - GATE_OFF: clk_divider_enable=0. Counter counts GATE_CYCLES cycles, then → LOAD.
  - LOAD (1 cycle): on exit, division_ratio ← captured ratio (only if captured ratio ≥ 2). clk_divider_enable ← (captured ratio ≥ 2). → SETTLE with counter=0.
  - SETTLE: holds outputs for SETTLE_CYCLES cycles, then → DONE.
  - DONE (1 cycle): done=1, done_id=served requester, done_bypass=~clk_divider_enable. → IDLE. No accept occurs in DONE.
- Ratios 0 and 1 request bypass: enable ends at 0 and division_ratio keeps its previous value.
- Latency, accept at cycle T:
  - Full path: done high at cycle T+GATE_CYCLES+SETTLE_CYCLES+2 (T+8 at defaults).
  - Fast path: done high at T+1.
- Requests arriving while busy wait. No queueing beyond the valid/ready hold.
- Counter is 4 bits and compares to parameter-1. No wrap occurs within the legal range.

Test Plan:
- Reset release, then req0_valid with req0_ratio=6 at cycle T → req0_ready=1 at T, enable=0 during T+1..T+3, division_ratio=6 and enable=1 from T+4, done=1 with done_id=0 and done_bypass=0 at T+8.
- req0 and req1 both valid in IDLE with ratios 4 and 5 → req0 served first (done_id=0). req1 is accepted the cycle after its done, ratio ends at 5, done_id=1. A repeated simultaneous pair then grants req1 first.
- With ratio=6 enabled, request ratio 6 → done at T+1, outputs unchanged, enable never drops.
- Request ratio 1 from a state of ratio=6 enabled → enable=0 from T+1 onward, division_ratio stays 6, done_bypass=1 at T+8. Ratio 0 gives the same response.
- Assert reset in SETTLE → next edge gives enable=0, division_ratio=2, busy=0, and no done pulse. A new request then completes normally.

Source files
------------

// File: rtl/clk_div_ratio_ctrl.sv
// Purpose : sequences divider ratio changes (gate-off -> load -> settle -> done) for two arbitrated requesters.
// Latency : accept at T -> done at T+GATE_CYCLES+SETTLE_CYCLES+2, or T+1 when the ratio is already active.
// Backpr. : ready is a one-cycle accept strobe, only in IDLE; requesters hold valid/ratio until they see it.
// Ports   : reference_clk/reset (sync, active-high); req{0,1}_valid/_ratio in, req{0,1}_ready out;
//           division_ratio/clk_divider_enable drive the divider; busy/done/done_id/done_bypass report status.
module clk_div_ratio_ctrl #(
  parameter int unsigned GATE_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [5:0]  RESET_RATIO   = 6'd2
) (
  input  logic       reference_clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [5:0] req0_ratio,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [5:0] req1_ratio,
  output logic       req1_ready,
  output logic [5:0] division_ratio,
  output logic       clk_divider_enable,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic       done_bypass
);

  typedef enum logic [2:0] {
    S_IDLE, S_GATE_OFF, S_LOAD, S_SETTLE, S_DONE
  } state_t;

  localparam logic [3:0] GATE_LAST   = 4'(GATE_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] ratio_q, ratio_d;
  logic [5:0] cap_q, cap_d;
  logic       en_q, en_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;   // requester granted on the most recent accept
  logic       id_q, id_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bypass_q, bypass_d;

  logic       grant_vld;
  logic       grant_id;
  logic [5:0] grant_ratio;

  // Contention goes to whoever was not served last; reset leaves last_q=1 so req0 wins first.
  always_comb begin
    grant_vld   = (state_q == S_IDLE) && (req0_valid || req1_valid);
    grant_id    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    grant_ratio = grant_id ? req1_ratio : req0_ratio;
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld && grant_id;

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    cap_d   = cap_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          cap_d  = grant_ratio;
          id_d   = grant_id;
          last_d = grant_id;
          // Ratio already running: nothing to touch, report straight away.
          if ((grant_ratio == ratio_q) && en_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GATE_OFF;
            cnt_d   = 4'd0;
            en_d    = 1'b0;
          end
        end
      end
      S_GATE_OFF: begin
        if (cnt_q == GATE_LAST) begin
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOAD: begin
        // Ratios 0/1 mean bypass: keep the old ratio, leave the divider disabled.
        if (cap_q >= 6'd2) begin
          ratio_d = cap_q;
        end
        en_d    = (cap_q >= 6'd2);
        cnt_d   = 4'd0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    bypass_d = (state_d == S_DONE) && !en_d;
  end

  always_ff @(posedge reference_clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ratio_q  <= RESET_RATIO;
      cap_q    <= 6'd0;
      en_q     <= 1'b0;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ratio_q  <= ratio_d;
      cap_q    <= cap_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bypass_q <= bypass_d;
    end
  end

  assign division_ratio     = ratio_q;
  assign clk_divider_enable = en_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign done_id            = id_q;
  assign done_bypass        = bypass_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Purpose : self-checking bench for clk_div_ratio_ctrl; scoreboard of expected completions checked on done.
// Latency : n/a (testbench).
// Backpr. : requesters hold valid until ready, as a real requester would.
module tb_clk_div_ratio_ctrl;

  localparam int GC = 2;
  localparam int SC = 4;

  logic       reference_clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [5:0] req0_ratio = 6'd0, req1_ratio = 6'd0;
  logic       req0_ready, req1_ready;
  logic [5:0] division_ratio;
  logic       clk_divider_enable, busy, done, done_id, done_bypass;

  clk_div_ratio_ctrl #(.GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .RESET_RATIO(6'd2)) dut (
    .reference_clk(reference_clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ratio(req0_ratio), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ratio(req1_ratio), .req1_ready(req1_ready),
    .division_ratio(division_ratio), .clk_divider_enable(clk_divider_enable),
    .busy(busy), .done(done), .done_id(done_id), .done_bypass(done_bypass)
  );

  always #5 reference_clk = ~reference_clk;

  typedef struct {
    bit         id;
    bit         bypass;
    logic [5:0] ratio;
    bit         en;
    int         lat;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         errs = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [5:0] m_ratio = 6'd2;
  bit         m_en = 1'b0;
  bit         m_last = 1'b1;

  always @(posedge reference_clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge reference_clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL sb_unexpected_done: done=1 id=%0d with no request outstanding", done_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (done_id !== e.id || done_bypass !== e.bypass || division_ratio !== e.ratio ||
            clk_divider_enable !== e.en || (cyc - e.t0) != e.lat) begin
          errs++;
          $display("FAIL sb_done: got id=%0d byp=%0d ratio=%0d en=%0d lat=%0d, want id=%0d byp=%0d ratio=%0d en=%0d lat=%0d",
                   done_id, done_bypass, division_ratio, clk_divider_enable, cyc - e.t0,
                   e.id, e.bypass, e.ratio, e.en, e.lat);
        end
      end
    end
  end

  task automatic tick;
    @(posedge reference_clk);
    #1;
  endtask

  // Reference model of the controller state, updated at each accept.
  task automatic push_exp(input bit id, input logic [5:0] r);
    exp_t e;
    bit   fast;
    fast = (r == m_ratio) && m_en;
    if (!fast) begin
      m_en = (r >= 6'd2);
      if (r >= 6'd2) m_ratio = r;
    end
    e.id     = id;
    e.bypass = !m_en;
    e.ratio  = m_ratio;
    e.en     = m_en;
    e.lat    = fast ? 1 : GC + SC + 2;
    e.t0     = cyc;
    m_last   = id;
    sb.push_back(e);
  endtask

  task automatic set_req(input bit id, input bit v, input logic [5:0] r);
    if (id) begin req1_valid = v; req1_ratio = r; end
    else    begin req0_valid = v; req0_ratio = r; end
  endtask

  // Presents a request, waits (bounded) for its ready, returns at cycle T+1.
  task automatic accept(input bit id, input logic [5:0] r);
    int n;
    set_req(id, 1'b1, r);
    #1;
    n = 0;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errs++;
      $display("FAIL accept_timeout: req%0d ready never rose, want ready=1", id);
    end
    push_exp(id, r);
    tick;
    set_req(id, 1'b0, r);
  endtask

  // Waits (bounded) until done is high; returns sampled inside the DONE cycle.
  task automatic wait_done;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errs++;
      $display("FAIL done_timeout: done=%0d after 40 cycles, want 1", done);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    tick;
    sb.delete();
    m_ratio = 6'd2; m_en = 1'b0; m_last = 1'b1;
    checks++;
    if ({division_ratio, clk_divider_enable, busy, done, done_id, done_bypass, req0_ready, req1_ready}
        !== {6'd2, 7'b0}) begin
      errs++;
      $display("FAIL reset_state: ratio=%0d en=%0d busy=%0d done=%0d id=%0d byp=%0d rdy=%0d%0d, want ratio=2 rest 0",
               division_ratio, clk_divider_enable, busy, done, done_id, done_bypass, req0_ready, req1_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
  endtask

  task automatic test_full_path;
    do_reset;
    set_req(0, 1'b1, 6'd6);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_ready: rdy0=%0d rdy1=%0d, want 1 0", req0_ready, req1_ready);
    end
    push_exp(0, 6'd6);
    tick;
    set_req(0, 1'b0, 6'd6);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (clk_divider_enable !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL full_gate T+%0d: en=%0d busy=%0d, want en=0 busy=1", k, clk_divider_enable, busy);
      end
      tick;
    end
    checks++;
    if (division_ratio !== 6'd6 || clk_divider_enable !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL full_load T+4: ratio=%0d en=%0d done=%0d, want 6 1 0", division_ratio, clk_divider_enable, done);
    end
    for (int k = 5; k <= 7; k++) begin
      tick;
      checks++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL full_early_done T+%0d: done=%0d, want 0", k, done);
      end
    end
    tick;
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL full_done T+8: done=%0d, want 1", done);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL full_after: done=%0d busy=%0d, want 0 0", done, busy);
    end
  endtask

  task automatic test_arbitration;
    bit exp_g;
    do_reset;
    set_req(0, 1'b1, 6'd4);
    set_req(1, 1'b1, 6'd5);
    #1;
    exp_g = ~m_last;
    checks++;
    if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
      errs++;
      $display("FAIL arb_pair1: rdy0=%0d rdy1=%0d, want %0d %0d", req0_ready, req1_ready, !exp_g, exp_g);
    end
    push_exp(exp_g, 6'd4);
    tick;
    set_req(0, 1'b0, 6'd4);
    checks++;
    if (req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL arb_busy_ready: rdy1=%0d while busy, want 0", req1_ready);
    end
    wait_done;
    checks++;
    if (req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL arb_done_ready: rdy1=%0d in DONE, want 0", req1_ready);
    end
    tick;
    checks++;
    if (req1_ready !== 1'b1) begin
      errs++;
      $display("FAIL arb_second_accept: rdy1=%0d cycle after done, want 1", req1_ready);
    end
    push_exp(1, 6'd5);
    tick;
    set_req(1, 1'b0, 6'd5);
    wait_done;
    tick;
    checks++;
    if (division_ratio !== 6'd5) begin
      errs++;
      $display("FAIL arb_ratio: ratio=%0d, want 5", division_ratio);
    end
    // A lone req0 leaves req1 as the favoured one for the next tie.
    accept(0, 6'd3);
    wait_done;
    tick;
    set_req(0, 1'b1, 6'd7);
    set_req(1, 1'b1, 6'd9);
    #1;
    exp_g = ~m_last;
    checks++;
    if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
      errs++;
      $display("FAIL arb_pair2: rdy0=%0d rdy1=%0d, want %0d %0d", req0_ready, req1_ready, !exp_g, exp_g);
    end
    push_exp(exp_g, exp_g ? 6'd9 : 6'd7);
    tick;
    set_req(exp_g, 1'b0, 6'd0);
    wait_done;
    tick;
    checks++;
    if ((exp_g ? req0_ready : req1_ready) !== 1'b1) begin
      errs++;
      $display("FAIL arb_pair2_second: loser ready=0, want 1");
    end
    push_exp(!exp_g, exp_g ? 6'd7 : 6'd9);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done;
    tick;
  endtask

  task automatic test_fast_path;
    do_reset;
    accept(0, 6'd6);
    wait_done;
    tick;
    set_req(1, 1'b1, 6'd6);
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errs++;
      $display("FAIL fast_ready: rdy1=%0d, want 1", req1_ready);
    end
    push_exp(1, 6'd6);
    tick;
    set_req(1, 1'b0, 6'd6);
    checks++;
    if (done !== 1'b1 || clk_divider_enable !== 1'b1 || division_ratio !== 6'd6) begin
      errs++;
      $display("FAIL fast_T1: done=%0d en=%0d ratio=%0d, want 1 1 6", done, clk_divider_enable, division_ratio);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || clk_divider_enable !== 1'b1) begin
      errs++;
      $display("FAIL fast_T2: done=%0d busy=%0d en=%0d, want 0 0 1", done, busy, clk_divider_enable);
    end
  endtask

  task automatic test_bypass;
    // Starts from ratio 6 enabled, left by test_fast_path.
    accept(0, 6'd1);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (clk_divider_enable !== 1'b0 || division_ratio !== 6'd6) begin
        errs++;
        $display("FAIL bypass1 T+%0d: en=%0d ratio=%0d, want 0 6", k, clk_divider_enable, division_ratio);
      end
      tick;
    end
    wait_done;
    tick;
    accept(1, 6'd0);
    wait_done;
    tick;
    checks++;
    if (clk_divider_enable !== 1'b0 || division_ratio !== 6'd6) begin
      errs++;
      $display("FAIL bypass0_after: en=%0d ratio=%0d, want 0 6", clk_divider_enable, division_ratio);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    accept(0, 6'd9);
    repeat (4) tick;
    checks++;
    if (busy !== 1'b1 || clk_divider_enable !== 1'b1) begin
      errs++;
      $display("FAIL mid_settle: busy=%0d en=%0d, want 1 1", busy, clk_divider_enable);
    end
    reset = 1'b1;
    tick;
    sb.delete();
    m_ratio = 6'd2; m_en = 1'b0; m_last = 1'b1;
    checks++;
    if (clk_divider_enable !== 1'b0 || division_ratio !== 6'd2 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: en=%0d ratio=%0d busy=%0d done=%0d, want 0 2 0 0",
               clk_divider_enable, division_ratio, busy, done);
    end
    reset = 1'b0;
    ndone = 0;
    repeat (10) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errs++;
      $display("FAIL mid_no_done: done pulses=%0d, want 0", ndone);
    end
    accept(1, 6'd7);
    wait_done;
    tick;
    checks++;
    if (division_ratio !== 6'd7 || clk_divider_enable !== 1'b1) begin
      errs++;
      $display("FAIL mid_recover: ratio=%0d en=%0d, want 7 1", division_ratio, clk_divider_enable);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_full_path;
    test_arbitration;
    test_fast_path;
    test_bypass;
    test_reset_mid;
    repeat (2) tick;
    checks++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL sb_leftover: %0d expected completions never seen, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
